// File: rtl/pwm_fade_bank.sv
// Purpose: bank of CHANNELS PWM outputs on one shared period counter, each ramping linearly toward a loaded target duty.
// Latency: pwm_out lags the counter compare by 1 cycle; loads take effect at the next period boundary (cnt == 2^WIDTH-2).
// Backpressure: 1-entry pending load; load_ready drops while it is full and returns the cycle after the boundary drains it.
// Optional: define PWM_FADE_DONE_EN to add fade_done, a 1-cycle pulse per channel when a ramp step reaches the target.
module pwm_fade_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int STEP_W   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load_target,
    input  logic [STEP_W-1:0]   step_period,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] ramp_busy,
    output logic                period_start
`ifdef PWM_FADE_DONE_EN
    ,
    output logic [CHANNELS-1:0] fade_done
`endif
);

    // Last count of a period; the period is 2^WIDTH-1 cycles so that a duty of all-ones is constant high.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]                 cnt_q, cnt_d;
    logic [STEP_W-1:0]                pc_q, pc_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   cur_q, cur_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   tgt_q, tgt_d;
    logic                             pend_full_q, pend_full_d;
    logic [CH_W-1:0]                  pend_ch_q, pend_ch_d;
    logic [WIDTH-1:0]                 pend_tgt_q, pend_tgt_d;
    logic                             load_ready_q;
    logic [CHANNELS-1:0]              pwm_q, pwm_d;
    logic                             period_start_q;
    logic                             boundary;
    logic                             accept;
    logic                             tick;
`ifdef PWM_FADE_DONE_EN
    logic [CHANNELS-1:0]              step_hit;
    logic [CHANNELS-1:0]              fade_done_q;
`endif

    assign boundary = (cnt_q == CNT_LAST);
    assign accept   = load_valid & load_ready_q;

    // Period counter and the 1-entry pending load register; a full entry is only ever cleared at a boundary.
    always_comb begin
        cnt_d       = boundary ? '0 : cnt_q + WIDTH'(1);
        pend_full_d = pend_full_q;
        pend_ch_d   = pend_ch_q;
        pend_tgt_d  = pend_tgt_q;
        if (pend_full_q) begin
            if (boundary) begin
                pend_full_d = 1'b0;
            end
        end else if (accept) begin
            pend_full_d = 1'b1;
            pend_ch_d   = load_ch;
            pend_tgt_d  = load_target;
        end
    end

    // Ramp prescaler: step_period is only looked at on the boundary cycle, so it may change at any time.
    always_comb begin
        pc_d = pc_q;
        tick = 1'b0;
        if (boundary) begin
            if (step_period == '0) begin
                pc_d = '0;
            end else if (pc_q >= step_period - STEP_W'(1)) begin
                tick = 1'b1;
                pc_d = '0;
            end else if (pc_q != '1) begin
                pc_d = pc_q + STEP_W'(1);
            end
        end
    end

    // Per-channel duty update: a pending write wins over a ramp step for the same channel in the same boundary.
    always_comb begin
        cur_d = cur_q;
        tgt_d = tgt_q;
        pwm_d = '0;
`ifdef PWM_FADE_DONE_EN
        step_hit = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < cur_q[i]);
            if (boundary && pend_full_q && (pend_ch_q == CH_W'(i))) begin
                tgt_d[i] = pend_tgt_q;
                if (step_period == '0) begin
                    cur_d[i] = pend_tgt_q;
                end
            end else if (tick && (cur_q[i] != tgt_q[i])) begin
                if (cur_q[i] < tgt_q[i]) begin
                    cur_d[i] = cur_q[i] + WIDTH'(1);
                end else begin
                    cur_d[i] = cur_q[i] - WIDTH'(1);
                end
`ifdef PWM_FADE_DONE_EN
                step_hit[i] = (cur_d[i] == tgt_q[i]);
`endif
            end
        end
    end

    // Busy flags come straight from the duty registers.
    always_comb begin
        ramp_busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ramp_busy[i] = (cur_q[i] != tgt_q[i]);
        end
    end

    // State registers; reset discards any pending load and holds load_ready low until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            pc_q           <= '0;
            cur_q          <= '0;
            tgt_q          <= '0;
            pend_full_q    <= 1'b0;
            pend_ch_q      <= '0;
            pend_tgt_q     <= '0;
            load_ready_q   <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            pc_q           <= pc_d;
            cur_q          <= cur_d;
            tgt_q          <= tgt_d;
            pend_full_q    <= pend_full_d;
            pend_ch_q      <= pend_ch_d;
            pend_tgt_q     <= pend_tgt_d;
            load_ready_q   <= !pend_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= (cnt_q == '0);
        end
    end

`ifdef PWM_FADE_DONE_EN
    // Completion pulse registered alongside the step that makes current equal target; jumps never set it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fade_done_q <= '0;
        end else begin
            fade_done_q <= step_hit;
        end
    end

    assign fade_done = fade_done_q;
`endif

    assign load_ready   = load_ready_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule
